// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//   Registered, time-multiplexed driver for eight active-low seven-segment
//   displays. It captures eight BCD digits and a sign flag from the upstream
//   binary-to-BCD converter on a load strobe. It then lights one digit
//   position at a time. Each position stays lit for REFRESH_DIV clock cycles.
//
// Optional feature (compile-time macro):
//   LEAD_ZERO_BLANK_EN - when defined, positions above the most significant
//   nonzero digit are blanked. A negative value also gets a minus glyph just
//   above that digit, when there is room for it. When undefined, all eight
//   positions show their decoded digit, and the sign appears on sign_led only.
//
// Parameters:
//   REFRESH_DIV  clock cycles per lit position (legal range 2..2^20)
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   load      in   capture strobe for the digits and neg
//   neg       in   sign from the converter (1 = negative)
//   first..eighth in  BCD digits, first = least significant
//   anode     out  one-hot active-low position enable, bit 0 = first
//   segments  out  active-low {g,f,e,d,c,b,a}
//   sign_led  out  registered copy of the captured sign
//   bcd_err   out  set when the last captured set held a digit above 9
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       neg,
    input  logic [3:0] first,
    input  logic [3:0] second,
    input  logic [3:0] third,
    input  logic [3:0] fourth,
    input  logic [3:0] fifth,
    input  logic [3:0] sixth,
    input  logic [3:0] seventh,
    input  logic [3:0] eighth,
    output logic [7:0] anode,
    output logic [6:0] segments,
    output logic       sign_led,
    output logic       bcd_err
);

    localparam logic [19:0] PRESC_LAST = 20'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam logic [6:0]  SEG_MINUS  = 7'h3F;

    // Active-low segment pattern for one BCD code; codes 10..15 are blank.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Digit inputs gathered into a packed vector; element i is position i.
    logic [7:0][3:0] digits_in;
    assign digits_in = {eighth, seventh, sixth, fifth, fourth, third, second, first};

    // Holding registers and scan state
    logic [7:0][3:0] digits_q, digits_d;
    logic            neg_q, neg_d;
    logic            bcd_err_q, bcd_err_d;
    logic [19:0]     presc_q, presc_d;
    logic [2:0]      idx_q, idx_d;

    // Output registers
    logic [7:0]      anode_q, anode_d;
    logic [6:0]      seg_q, seg_d;
    logic            sign_q, sign_d;

    logic [6:0]      glyph;

    // Capture. The error flag is recomputed from the newly loaded digits, so
    // it follows the latest load and holds its value between loads.
    always_comb begin
        digits_d  = digits_q;
        neg_d     = neg_q;
        bcd_err_d = bcd_err_q;
        if (load) begin
            digits_d  = digits_in;
            neg_d     = neg;
            bcd_err_d = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (digits_in[i] > 4'd9) begin
                    bcd_err_d = 1'b1;
                end
            end
        end
    end

    // Prescaler: the position index advances once every REFRESH_DIV cycles.
    always_comb begin
        presc_d = presc_q + 20'd1;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = 20'd0;
            idx_d   = idx_q + 3'd1;   // 7 wraps naturally to 0
        end
    end

    // Glyph for the position being scanned, taken from the current holding
    // registers.
`ifdef LEAD_ZERO_BLANK_EN
    logic [2:0] msd;

    always_comb begin
        // Highest nonzero position. If all digits are zero, this stays at 0,
        // so position 0 is always shown.
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (digits_q[i] != 4'd0) begin
                msd = 3'(i);
            end
        end

        glyph = decode(digits_q[idx_q]);
        if (idx_q > msd) begin
            // When msd is 7, this branch is never taken, so there is no wrap.
            if (neg_q && (idx_q == msd + 3'd1)) begin
                glyph = SEG_MINUS;
            end else begin
                glyph = SEG_BLANK;
            end
        end
    end
`else
    always_comb begin
        glyph = decode(digits_q[idx_q]);
    end
`endif

    // The output stage reflects the index and holding registers as they were
    // before the edge. This gives one cycle of latency after a load.
    always_comb begin
        anode_d = ~(8'd1 << idx_q);
        seg_d   = glyph;
        sign_d  = neg_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits_q  <= '0;
            neg_q     <= 1'b0;
            bcd_err_q <= 1'b0;
            presc_q   <= 20'd0;
            idx_q     <= 3'd0;
            anode_q   <= 8'hFF;
            seg_q     <= SEG_BLANK;
            sign_q    <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            neg_q     <= neg_d;
            bcd_err_q <= bcd_err_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
            sign_q    <= sign_d;
        end
    end

    assign anode    = anode_q;
    assign segments = seg_q;
    assign sign_led = sign_q;
    assign bcd_err  = bcd_err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed and randomized stimulus for seg7_scan_driver with REFRESH_DIV=4.
// The reference model uses time arithmetic and the display rules:
//   - Output edge k after reset release shows position ((k-1)/D) mod 8.
//   - That edge shows the data captured by loads up to edge k-1.
// Honours LEAD_ZERO_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    logic       neg;
    logic [3:0] first, second, third, fourth, fifth, sixth, seventh, eighth;
    logic [7:0] anode;
    logic [6:0] segments;
    logic       sign_led;
    logic       bcd_err;

    seg7_scan_driver #(.REFRESH_DIV(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .neg      (neg),
        .first    (first),
        .second   (second),
        .third    (third),
        .fourth   (fourth),
        .fifth    (fifth),
        .sixth    (sixth),
        .seventh  (seventh),
        .eighth   (eighth),
        .anode    (anode),
        .segments (segments),
        .sign_led (sign_led),
        .bcd_err  (bcd_err)
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [3:0] m_dig [8];
    logic       m_neg;
    logic       m_err;
    int         e;          // edges since reset release

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_glyph(input int pos);
`ifdef LEAD_ZERO_BLANK_EN
        int top;
        top = 0;
        for (int i = 0; i < 8; i++) if (m_dig[i] != 4'd0) top = i;
        if (pos <= top) return seg_of(m_dig[pos]);
        if (m_neg && pos == top + 1) return 7'h3F;
        return 7'h7F;
`else
        return seg_of(m_dig[pos]);
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, obs, exp);
        end
    endtask

    task automatic set_digits(input logic [31:0] v, input logic s);
        first = v[3:0];    second  = v[7:4];   third  = v[11:8];  fourth = v[15:12];
        fifth = v[19:16];  sixth   = v[23:20]; seventh = v[27:24]; eighth = v[31:28];
        neg   = s;
    endtask

    // One clock edge: predict outputs from pre-edge model, then update model.
    task automatic tick(input logic ld);
        int pos;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_sign;
        logic [31:0] v;
        load = ld;
        @(posedge clock);
        e++;
        pos      = ((e - 1) / D) % 8;
        exp_an   = ~(8'd1 << pos);
        exp_seg  = exp_glyph(pos);
        exp_sign = m_neg;
        if (ld) begin
            v = {eighth, seventh, sixth, fifth, fourth, third, second, first};
            m_err = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_dig[i] = v[4*i +: 4];
                if (m_dig[i] > 4'd9) m_err = 1'b1;
            end
            m_neg = neg;
        end
        #1;
        check("anode", anode, exp_an);
        check("segments", {1'b0, segments}, {1'b0, exp_seg});
        check("sign_led", {7'd0, sign_led}, {7'd0, exp_sign});
        check("bcd_err", {7'd0, bcd_err}, {7'd0, m_err});
        load = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;
        m_neg = 1'b0;
        m_err = 1'b0;
        e     = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_anode", anode, 8'hFF);
        check("rst_segments", {1'b0, segments}, 8'h7F);
        check("rst_sign_led", {7'd0, sign_led}, 8'h00);
        check("rst_bcd_err", {7'd0, bcd_err}, 8'h00);
    endtask

    task automatic load_and_frame(input logic [31:0] v, input logic s);
        set_digits(v, s);
        tick(1'b1);
        for (int i = 0; i < 8 * D + 2; i++) tick(1'b0);
    endtask

    initial begin
        logic [31:0] rv;
        int nz;

        // Power-up reset
        reset = 1'b1;
        load  = 1'b0;
        set_digits(32'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        // Free-running scan over more than one full frame
        for (int i = 0; i < 8 * D + 6; i++) tick(1'b0);

        // Put state in place so the reset check is meaningful, then reset mid-scan
        set_digits(32'h0000B125, 1'b1);
        tick(1'b1);
        repeat (5) tick(1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < 8 * D + 4; i++) tick(1'b0);

        // Directed displays
        load_and_frame(32'h00000125, 1'b0);
        load_and_frame(32'h00000042, 1'b1);
        load_and_frame(32'h98765432, 1'b1);
        load_and_frame(32'h00000000, 1'b0);
        load_and_frame(32'h0000B321, 1'b0);   // bad digit at position 3
        load_and_frame(32'h00004321, 1'b0);   // clean load clears the error

        // Load on the same edge that advances the index
        while ((e + 1) % D != 0) tick(1'b0);
        set_digits(32'h87654321, 1'b0);
        tick(1'b1);
        repeat (D + 2) tick(1'b0);

        // Three back-to-back loads; only the last one sticks
        set_digits(32'h11111111, 1'b1); tick(1'b1);
        set_digits(32'h22222222, 1'b0); tick(1'b1);
        set_digits(32'h00000307, 1'b1); tick(1'b1);
        for (int i = 0; i < 8 * D + 2; i++) tick(1'b0);

        // Randomized loads with varying leading-zero counts, signs and gaps
        for (int n = 0; n < 16; n++) begin
            nz = $urandom_range(0, 8);
            rv = 32'h0;
            for (int i = 0; i < nz; i++) begin
                if ($urandom_range(0, 9) == 0) rv[4*i +: 4] = 4'($urandom_range(10, 15));
                else                           rv[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            set_digits(rv, 1'($urandom_range(0, 1)));
            tick(1'b1);
            repeat ($urandom_range(1, 8 * D + 4)) tick(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
